// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default width and counter sizing.
package div_seq_pkg;

    localparam int DIV_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_seq_cls_sub.sv
// WIDTH-bit carry-lookahead subtractor: a + ~b + 1, built from 4-bit lookahead
// groups whose group carries ripple from nibble to nibble. WIDTH must be a multiple of 4.
module cls_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             carry_out
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] bn;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NG:0]      gc;

    assign bn    = ~b;
    assign g     = a & bn;
    assign p     = a ^ bn;
    assign gc[0] = 1'b1;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        logic [3:0] gg;
        logic [3:0] pp;
        logic [4:0] c;

        assign gg   = g[4*gi +: 4];
        assign pp   = p[4*gi +: 4];
        assign c[0] = gc[gi];
        // Every carry inside the nibble is formed directly from the group inputs.
        assign c[1] = gg[0] | (pp[0] & c[0]);
        assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
        assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                    | (pp[2] & pp[1] & pp[0] & c[0]);
        assign c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0])
                    | (pp[3] & pp[2] & pp[1] & pp[0] & c[0]);

        assign diff[4*gi +: 4] = pp ^ c[3:0];
        assign gc[gi+1]        = c[4];
    end

    assign carry_out = gc[NG];

endmodule

// File: rtl/div_seq.sv
// Iterative unsigned restoring divider, one trial subtraction per clock.
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes one edge after acceptance.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_cout;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] r_nxt;

    assign r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    cls_sub #(.WIDTH(WIDTH)) u_sub (
        .a         (r_shift),
        .b         (d_q),
        .diff      (sub_diff),
        .carry_out (sub_cout)
    );

    // No borrow (carry out set) means the divisor fits: keep the difference.
    assign r_nxt = sub_cout ? sub_diff : r_shift;
    assign q_nxt = {q_q[WIDTH-2:0], sub_cout};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    dz_d    = (divisor == '0);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef DIV_ZERO_FAST_EN
                if (dz_q) begin
                    quo_d   = '1;
                    rem_d   = q_q;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else
`endif
                begin
                    q_d   = q_nxt;
                    r_d   = r_nxt;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quo_d   = q_nxt;
                        rem_d   = r_nxt;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at WIDTH=8 and WIDTH=16 against a plain
// arithmetic reference (a/b, a%b, zero divisor -> all ones / dividend).
module tb_div_seq;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start8, start16;
    logic [7:0]  dvd8, dvs8;
    logic [15:0] dvd16, dvs16;
    logic        busy8, done8, dz8;
    logic        busy16, done16, dz16;
    logic [7:0]  quo8, rem8;
    logic [15:0] quo16, rem16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .dz(dz8)
    );

    div_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .dividend(dvd16), .divisor(dvs16),
        .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16), .dz(dz16)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        logic [7:0] eq, er;
        if (b == 0) begin eq = 8'hff; er = a; end
        else begin eq = a / b; er = a % b; end
        @(negedge clk);
        start8 = 1'b1; dvd8 = a; dvs8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
        chk("busy8_after_accept", busy8, 1);
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("done8_seen", done8, 1);
        chk("lat8", lat, (FAST && b == 0) ? 1 : 8);
        chk("quo8", quo8, eq);
        chk("rem8", rem8, er);
        chk("dz8", dz8, b == 0);
        chk("busy8_at_done", busy8, 0);
        if (b != 0) begin
            chk("ident8", 32'(quo8) * 32'(b) + 32'(rem8), 32'(a));
            chk("rem8_lt_div", rem8 < b, 1);
        end
        @(posedge clk); #1;
        chk("done8_drop", done8, 0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        int lat;
        logic [15:0] eq, er;
        if (b == 0) begin eq = 16'hffff; er = a; end
        else begin eq = a / b; er = a % b; end
        @(negedge clk);
        start16 = 1'b1; dvd16 = a; dvs16 = b;
        @(posedge clk); #1;
        start16 = 1'b0; dvd16 = 16'($urandom); dvs16 = 16'($urandom);
        lat = 0;
        while (!done16 && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("done16_seen", done16, 1);
        chk("lat16", lat, (FAST && b == 0) ? 1 : 16);
        chk("quo16", quo16, eq);
        chk("rem16", rem16, er);
        chk("dz16", dz16, b == 0);
        if (b != 0) begin
            chk("ident16", 32'(quo16) * 32'(b) + 32'(rem16), 32'(a));
            chk("rem16_lt_div", rem16 < b, 1);
        end
        @(posedge clk); #1;
        chk("done16_drop", done16, 0);
    endtask

    initial begin
        int lat;
        bit seen;
        reset_n = 1'b0;
        start8 = 1'b0; dvd8 = '0; dvs8 = '0;
        start16 = 1'b0; dvd16 = '0; dvs16 = '0;
        #12;
        chk("reset8_outs", {busy8, done8, dz8, quo8, rem8}, 0);
        chk("reset16_outs", {busy16, done16, dz16, quo16, rem16}, 0);
        reset_n = 1'b1;

        op8(8'd200, 8'd7);

        // Reset in the middle of an operation
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_outs", {busy8, done8, dz8, quo8, rem8}, 0);
        #3;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done8) seen = 1'b1; end
        chk("no_done_after_reset", seen, 0);
        op8(8'd200, 8'd7);

        op8(8'd255, 8'd1);
        op8(8'd5, 8'd9);
        op8(8'd0, 8'd3);
        op8(8'd255, 8'd255);
        op8(8'd100, 8'd0);
        op8(8'd200, 8'd7);

        // start held high: second operands ignored while busy, taken on the done cycle
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd6;
        @(posedge clk); #1;
        dvd8 = 8'd13; dvs8 = 8'd13;
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("hs1_lat", lat, 8);
        chk("hs1_quo", quo8, 8);
        chk("hs1_rem", rem8, 2);
        @(posedge clk); #1;
        chk("hs_done_drop", done8, 0);
        chk("hs2_busy", busy8, 1);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("hs2_lat", lat, 8);
        chk("hs2_quo", quo8, 1);
        chk("hs2_rem", rem8, 0);
        @(posedge clk); #1;
        chk("hs2_done_drop", done8, 0);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] b;
            b = (i % 97 == 0) ? 8'd0 : 8'($urandom);
            op8(8'($urandom), b);
        end
        op16(16'd60000, 16'd7);
        op16(16'd1234, 16'd0);
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] b;
            b = (i % 89 == 0) ? 16'd0 : ((i % 2 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom));
            op16(16'($urandom), b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
